fetch_unit: RTL and testbench

Instruction-fetch stage of the 8-bit RISC-V pipeline. Owns the program counter, drives a synchronous-read instruction memory, and registers the fetched PC and valid bit into the IF/ID boundary that feeds the decode stage. It supports decode-stage stalls and branch redirects from the execute stage. It hands decode a stable 32-bit instruction, its PC, and a valid flag; a NOP replaces the instruction when the slot is empty.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/pc_register.sv | 40 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the 8-bit RISC-V pipeline: NOP encoding and fetch defaults.
package riscv_pkg;

   localparam int          PC_WIDTH_DEF = 8;
   localparam int          RESET_PC_DEF = 0;
   localparam logic [31:0] NOP          = 32'h0000_0013;

endpackage

// File: rtl/pc_register.sv
// Program counter for the fetch stage: holds fetch_pc and computes its next value.
module pc_register
   import riscv_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic [PC_WIDTH-1:0] fetch_pc,
   output logic [PC_WIDTH-1:0] target_aligned
);

   logic [PC_WIDTH-1:0] next_pc;

   assign target_aligned = branch_target & ~PC_WIDTH'(3);

   // A redirect fetches the target now, so the following fetch is target+4.
   // Arithmetic wraps modulo 2^PC_WIDTH.
   always_comb begin
      next_pc = fetch_pc;
      if (branch_taken) begin
         next_pc = target_aligned + PC_WIDTH'(4);
      end else if (!stall) begin
         next_pc = fetch_pc + PC_WIDTH'(4);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
      end else begin
         fetch_pc <= next_pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem address mux and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/redirect counters.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         id_instruction,
   output logic [PC_WIDTH-1:0] id_pc,
   output logic                id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]         fetch_count,
   output logic [15:0]         redirect_count
`endif
);

   logic [PC_WIDTH-1:0] fetch_pc;
   logic [PC_WIDTH-1:0] target_aligned;
   logic                load_id;

   pc_register #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .fetch_pc       (fetch_pc),
      .target_aligned (target_aligned)
   );

   assign load_id = branch_taken || !stall;

   // During a stall the held PC is re-read so imem_rdata stays stable.
   always_comb begin
      imem_addr = fetch_pc;
      if (branch_taken) begin
         imem_addr = target_aligned;
      end else if (stall) begin
         imem_addr = id_pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_pc    <= '0;
         id_valid <= 1'b0;
      end else if (load_id) begin
         id_pc    <= branch_taken ? target_aligned : fetch_pc;
         id_valid <= 1'b1;
      end
   end

   assign id_instruction = id_valid ? imem_rdata : NOP;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_count    <= '0;
         redirect_count <= '0;
      end else begin
         if (load_id && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (branch_taken && redirect_count != 16'hFFFF) begin
            redirect_count <= redirect_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a synchronous-read memory model and a PC-level reference.
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] id_instruction;
   logic [7:0]  id_pc;
   logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
   logic [15:0] redirect_count;
`endif

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_instruction (id_instruction),
      .id_pc          (id_pc),
      .id_valid       (id_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
`endif
   );

   // clock / memory
   always #5 clock = ~clock;

   logic [31:0] mem [64];
   always @(posedge clock) imem_rdata <= mem[imem_addr[7:2]];

   int total = 0;
   int bad   = 0;

   // reference model: architectural view of the fetch stage
   logic [7:0] m_fetch;
   logic [7:0] m_pc;
   logic       m_valid;
   int         m_fcnt;
   int         m_rcnt;
   logic [7:0] exp_addr;
   logic [7:0] obs_addr;
   logic [7:0] exp_q[$];

   function automatic logic [31:0] exp_instr();
      return m_valid ? mem[m_pc[7:2]] : NOP;
   endfunction

   task automatic model_reset();
      m_fetch = 8'h00;
      m_pc    = 8'h00;
      m_valid = 1'b0;
      m_fcnt  = 0;
      m_rcnt  = 0;
   endtask

   // driver: called 1 time unit after a rising edge; returns 1 unit after the next one
   task automatic step(input logic s, input logic b, input logic [7:0] t);
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      #1;
      exp_addr = b ? (t & 8'hFC) : (s ? m_pc : m_fetch);
      obs_addr = imem_addr;
      @(posedge clock);
      if (b) begin
         m_pc    = t & 8'hFC;
         m_fetch = m_pc + 8'd4;
         m_valid = 1'b1;
      end else if (!s) begin
         m_pc    = m_fetch;
         m_fetch = m_fetch + 8'd4;
         m_valid = 1'b1;
      end
      if ((b || !s) && m_fcnt < 65535) m_fcnt++;
      if (b && m_rcnt < 65535) m_rcnt++;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      total++; if (id_pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", id_pc); end
      total++; if (id_instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", id_instruction, NOP); end
      total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      exp_q = '{8'h00, 8'h04};
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 8'h00);
         total++; if (id_pc !== exp_q[i]) begin bad++; $display("FAIL seq_pc got=%h exp=%h", id_pc, exp_q[i]); end
         total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", id_valid); end
         total++; if (id_instruction !== mem[i]) begin bad++; $display("FAIL seq_instr got=%h exp=%h", id_instruction, mem[i]); end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h00);
         total++; if (obs_addr !== 8'h04) begin bad++; $display("FAIL stall_addr got=%h exp=04", obs_addr); end
         total++; if (id_pc !== 8'h04) begin bad++; $display("FAIL stall_pc got=%h exp=04", id_pc); end
         total++; if (id_instruction !== mem[1]) begin bad++; $display("FAIL stall_instr got=%h exp=%h", id_instruction, mem[1]); end
      end
      step(1'b0, 1'b0, 8'h00);
      total++; if (id_pc !== 8'h08) begin bad++; $display("FAIL unstall_pc got=%h exp=08", id_pc); end
      total++; if (id_instruction !== mem[2]) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", id_instruction, mem[2]); end
   endtask

   task automatic test_branch();
      step(1'b0, 1'b1, 8'h41);
      total++; if (obs_addr !== 8'h40) begin bad++; $display("FAIL br_addr got=%h exp=40", obs_addr); end
      total++; if (id_pc !== 8'h40) begin bad++; $display("FAIL br_pc got=%h exp=40", id_pc); end
      total++; if (id_instruction !== mem[16]) begin bad++; $display("FAIL br_instr got=%h exp=%h", id_instruction, mem[16]); end
      step(1'b0, 1'b0, 8'h00);
      total++; if (id_pc !== 8'h44) begin bad++; $display("FAIL br_next_pc got=%h exp=44", id_pc); end
      total++; if (id_instruction !== mem[17]) begin bad++; $display("FAIL br_next_instr got=%h exp=%h", id_instruction, mem[17]); end
   endtask

   task automatic test_branch_stall();
      step(1'b1, 1'b1, 8'h83);
      total++; if (id_pc !== 8'h80) begin bad++; $display("FAIL brst_pc got=%h exp=80", id_pc); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL brst_valid got=%b exp=1", id_valid); end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 8'h00);
         total++; if (id_pc !== 8'h80) begin bad++; $display("FAIL brst_hold_pc got=%h exp=80", id_pc); end
         total++; if (id_instruction !== mem[32]) begin bad++; $display("FAIL brst_hold_instr got=%h exp=%h", id_instruction, mem[32]); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      exp_q = '{8'hF8, 8'hFC, 8'h00, 8'h04};
      step(1'b0, 1'b1, 8'hF8);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step(1'b0, 1'b0, 8'h00);
         e = exp_q.pop_front();
         total++; if (id_pc !== e) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", id_pc, e); end
         total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", id_valid); end
         total++; if (id_instruction !== mem[e[7:2]]) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", id_instruction, mem[e[7:2]]); end
      end
   endtask

   task automatic test_random();
      logic s, b;
      for (int i = 0; i < 200; i++) begin
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 7) == 0);
         step(s, b, 8'($urandom_range(0, 255)));
         total++; if (obs_addr !== exp_addr) begin bad++; $display("FAIL rnd_addr got=%h exp=%h", obs_addr, exp_addr); end
         total++; if (id_pc !== m_pc) begin bad++; $display("FAIL rnd_pc got=%h exp=%h", id_pc, m_pc); end
         total++; if (id_valid !== m_valid) begin bad++; $display("FAIL rnd_valid got=%b exp=%b", id_valid, m_valid); end
         total++; if (id_instruction !== exp_instr()) begin bad++; $display("FAIL rnd_instr got=%h exp=%h", id_instruction, exp_instr()); end
      end
`ifdef FETCH_PERF_CNT_EN
      total++; if (fetch_count !== 16'(m_fcnt)) begin bad++; $display("FAIL fetch_count got=%0d exp=%0d", fetch_count, m_fcnt); end
      total++; if (redirect_count !== 16'(m_rcnt)) begin bad++; $display("FAIL redirect_count got=%0d exp=%0d", redirect_count, m_rcnt); end
`endif
   endtask

   task automatic test_reset_midstream();
      step(1'b0, 1'b0, 8'h00);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", id_valid); end
      total++; if (id_instruction !== NOP) begin bad++; $display("FAIL mid_reset_instr got=%h exp=%h", id_instruction, NOP); end
      total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL mid_reset_addr got=%h exp=00", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL mid_reset_fcnt got=%0d exp=0", fetch_count); end
      total++; if (redirect_count !== 16'd0) begin bad++; $display("FAIL mid_reset_rcnt got=%0d exp=0", redirect_count); end
`endif
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      total++; if (id_pc !== 8'h00) begin bad++; $display("FAIL post_reset_pc got=%h exp=00", id_pc); end
      total++; if (id_instruction !== mem[0]) begin bad++; $display("FAIL post_reset_instr got=%h exp=%h", id_instruction, mem[0]); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_branch_stall();
      test_wrap();
      test_random();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
